// File: rtl/pic_inta_sequencer.sv
// 8259A INTA-cycle sequencer: INT request, two-pulse INTA handshake, ISR strobes.
// Define PIC_ACK_TIMEOUT_EN to abort a strobe whose toggle ack never arrives.
module pic_inta_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       intReq,
  input  logic       INTA_n,
  input  logic       readPriorityAck,
  input  logic       sendVectorAck,
  output logic       INT,
  output logic       readPriority,
  output logic       sendVector,
  output logic       secondACK,
  output logic       dataBufferOE,
  output logic       seqError,
  output logic [2:0] seqState
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    FREEZE = 3'd2,
    WAIT2  = 3'd3,
    VECT   = 3'd4,
    DRIVE  = 3'd5,
    ACK2   = 3'd6
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic inta_prev_q;
  logic rp_trk_q, sv_trk_q;
  logic inta_s, fall, rise;
  logic rp_seen, sv_seen, timeout;

  assign inta_s  = sync_q[SYNC_STAGES-1];
  assign fall    = inta_prev_q & ~inta_s;
  assign rise    = ~inta_prev_q & inta_s;
  assign rp_seen = readPriorityAck != rp_trk_q;
  assign sv_seen = sendVectorAck != sv_trk_q;

`ifdef PIC_ACK_TIMEOUT_EN
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic          waiting;

  assign waiting = (state_q == FREEZE && !rp_seen)
                || (state_q == VECT && !sv_seen);
  assign timeout = waiting && (cnt_q == CW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (waiting) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = |ACK_TIMEOUT;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (intReq) state_d = REQ;
      REQ:    if (fall) state_d = FREEZE;
      FREEZE: begin
        if (rp_seen) state_d = WAIT2;
        else if (timeout) state_d = IDLE;
      end
      WAIT2:  if (fall) state_d = VECT;
      VECT:   begin
        if (sv_seen) state_d = DRIVE;
        else if (timeout) state_d = IDLE;
      end
      DRIVE:  if (rise) state_d = ACK2;
      ACK2:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Trackers follow the ack lines every cycle, so stray toggles are absorbed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sync_q       <= '1;
      inta_prev_q  <= 1'b1;
      rp_trk_q     <= 1'b0;
      sv_trk_q     <= 1'b0;
      INT          <= 1'b0;
      readPriority <= 1'b0;
      sendVector   <= 1'b0;
      secondACK    <= 1'b0;
      dataBufferOE <= 1'b0;
      seqError     <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], INTA_n};
      inta_prev_q  <= inta_s;
      rp_trk_q     <= readPriorityAck;
      sv_trk_q     <= sendVectorAck;
      state_q      <= state_d;
      INT          <= state_d == REQ;
      readPriority <= state_d == FREEZE;
      sendVector   <= state_d == VECT;
      secondACK    <= state_d == ACK2;
      dataBufferOE <= state_d == DRIVE;
      seqError     <= timeout;
    end
  end

  assign seqState = state_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Randomised bench for pic_inta_sequencer against a cycle model of the INTA rules.
// Directed literal checks pin reset, latency, nesting, reset-abort and timeout.
module tb_pic_inta_sequencer;

  localparam int S   = 2;
  localparam int TMO = 16;
`ifdef PIC_ACK_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       intReq = 1'b0;
  logic       INTA_n = 1'b1;
  logic       readPriorityAck = 1'b0;
  logic       sendVectorAck = 1'b0;
  logic       INT, readPriority, sendVector, secondACK;
  logic       dataBufferOE, seqError;
  logic [2:0] seqState;

  int compared = 0;
  int mismatched = 0;

  pic_inta_sequencer #(.SYNC_STAGES(S), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .intReq(intReq),
    .INTA_n(INTA_n),
    .readPriorityAck(readPriorityAck),
    .sendVectorAck(sendVectorAck),
    .INT(INT),
    .readPriority(readPriority),
    .sendVector(sendVector),
    .secondACK(secondACK),
    .dataBufferOE(dataBufferOE),
    .seqError(seqError),
    .seqState(seqState)
  );

  always #5 clk = ~clk;

  logic [8:0] outs;
  assign outs = {INT, readPriority, sendVector, secondACK,
                 dataBufferOE, seqError, seqState};

  // Model: pin history as a delay line, acks as change-since-last-edge.
  int        phase;
  int        cyc_n;
  int        enter_cyc;
  bit [15:0] pins;
  bit        rp_last, sv_last, exp_err;

  always @(posedge clk or posedge reset) begin
    bit fall, rise, rp_ack, sv_ack, tmo;
    int nxt;
    if (reset) begin
      phase = 0; cyc_n = 0; enter_cyc = 0;
      pins = '1; rp_last = 0; sv_last = 0; exp_err = 0;
    end else begin
      cyc_n++;
      fall   = pins[S] && !pins[S-1];
      rise   = !pins[S] && pins[S-1];
      rp_ack = readPriorityAck != rp_last;
      sv_ack = sendVectorAck != sv_last;
      tmo    = 0;
      nxt    = phase;
      case (phase)
        0: if (intReq) nxt = 1;
        1: if (fall) nxt = 2;
        2: if (rp_ack) nxt = 3;
           else if (TMO_ON && cyc_n - enter_cyc == TMO) begin tmo = 1; nxt = 0; end
        3: if (fall) nxt = 4;
        4: if (sv_ack) nxt = 5;
           else if (TMO_ON && cyc_n - enter_cyc == TMO) begin tmo = 1; nxt = 0; end
        5: if (rise) nxt = 6;
        default: nxt = 0;
      endcase
      if (nxt != phase && (nxt == 2 || nxt == 4)) enter_cyc = cyc_n;
      phase   = nxt;
      exp_err = tmo;
      pins    = {pins[14:0], INTA_n};
      rp_last = readPriorityAck;
      sv_last = sendVectorAck;
    end
  end

  function automatic logic [8:0] model_outs();
    return {phase == 1, phase == 2, phase == 4, phase == 6,
            phase == 5, exp_err, 3'(phase)};
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      compared++;
      if (outs !== model_outs()) begin
        mismatched++;
        $display("FAIL model t=%0t: got %b expected %b", $time, outs, model_outs());
      end
    end
  end

  task automatic chk(input string name, input logic [8:0] exp);
    compared++;
    if (outs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b", name, outs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  localparam logic [8:0] O_IDLE = 9'b000000_000;
  localparam logic [8:0] O_REQ  = 9'b100000_001;
  localparam logic [8:0] O_FRZ  = 9'b010000_010;
  localparam logic [8:0] O_W2   = 9'b000000_011;
  localparam logic [8:0] O_VECT = 9'b001000_100;
  localparam logic [8:0] O_DRV  = 9'b000010_101;
  localparam logic [8:0] O_ACK2 = 9'b000100_110;
  localparam logic [8:0] O_ERR  = 9'b000001_000;

  initial begin
    int hold;
    cyc(3);
    reset = 1'b0;
    chk("reset_state", O_IDLE);

    INTA_n = 1'b0; cyc(5);
    chk("idle_fall", O_IDLE);
    INTA_n = 1'b1; sendVectorAck = 1'b1; cyc(5);
    chk("idle_rise_stray_ack", O_IDLE);

    intReq = 1'b1; cyc(1);
    chk("int_latency", O_REQ);
    INTA_n = 1'b0; cyc(S);
    chk("rp_not_early", O_REQ);
    cyc(1);
    chk("rp_latency", O_FRZ);
    INTA_n = 1'b1; readPriorityAck = 1'b1; cyc(1);
    chk("rp_ack", O_W2);
    cyc(4);
    chk("wait2_rise_ignored", O_W2);
    INTA_n = 1'b0; cyc(S + 1);
    chk("sv_latency", O_VECT);
    sendVectorAck = 1'b0; cyc(1);
    chk("sv_ack", O_DRV);
    INTA_n = 1'b1; cyc(S);
    chk("drive_hold", O_DRV);
    cyc(1);
    chk("second_ack", O_ACK2);
    cyc(1);
    chk("ack2_to_idle", O_IDLE);
    cyc(1);
    chk("nest_reenter", O_REQ);

    intReq = 1'b0; cyc(3);
    chk("req_held_no_intreq", O_REQ);
    INTA_n = 1'b0; cyc(S + 1);
    chk("spurious_freeze", O_FRZ);
    readPriorityAck = 1'b0; INTA_n = 1'b1; cyc(1);
    chk("spurious_w2", O_W2);
    cyc(3);
    INTA_n = 1'b0; cyc(S + 1);
    chk("spurious_vect", O_VECT);
    reset = 1'b1; #1;
    chk("reset_in_vect", O_IDLE);
    sendVectorAck = 1'b1; INTA_n = 1'b1;
    cyc(1);
    reset = 1'b0; cyc(4);
    chk("ack_after_reset", O_IDLE);

    intReq = 1'b1; cyc(1);
    intReq = 1'b0; INTA_n = 1'b0; cyc(S + 1);
    chk("tmo_freeze", O_FRZ);
    INTA_n = 1'b1;
`ifdef PIC_ACK_TIMEOUT_EN
    cyc(TMO - 1);
    chk("tmo_not_early", O_FRZ);
    cyc(1);
    chk("tmo_error", O_ERR);
    cyc(1);
    chk("tmo_pulse_end", O_IDLE);
`else
    cyc(40);
    chk("no_tmo_wait", O_FRZ);
    readPriorityAck = ~readPriorityAck; cyc(1);
    chk("late_ack", O_W2);
`endif
    reset = 1'b1; cyc(2);
    reset = 1'b0; cyc(1);

    hold = 1;
    for (int i = 0; i < 3000; i++) begin
      intReq = ($urandom_range(0, 3) != 0);
      hold--;
      if (hold == 0) begin
        INTA_n = ~INTA_n;
        hold = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 7) == 0) readPriorityAck = ~readPriorityAck;
      if ($urandom_range(0, 7) == 0) sendVectorAck = ~sendVectorAck;
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1; cyc(1);
        reset = 1'b0;
      end
      cyc(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
